io_bidir_arbiter: RTL and testbench



---
 rtl/io_bidir_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_io_bidir_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/io_bidir_arbiter.sv
// Half-duplex pad-group controller: round-robin transmit bursts for two requesters
// with a default receive path and guaranteed dead time at every direction change.
module io_bidir_arbiter #(
    parameter int WIDTH      = 8,
    parameter int LEN_W      = 4,
    parameter int TURNAROUND = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQ0,
    input  logic             REQ1,
    input  logic [LEN_W-1:0] LEN0,
    input  logic [LEN_W-1:0] LEN1,
    input  logic [WIDTH-1:0] DATA0,
    input  logic [WIDTH-1:0] DATA1,
    output logic             GNT0,
    output logic             GNT1,
    output logic             ACK0,
    output logic             ACK1,
    output logic [WIDTH-1:0] PAD_O,
    output logic             PAD_T,
    output logic             PAD_EN,
    input  logic [WIDTH-1:0] PAD_I,
    output logic [WIDTH-1:0] RX_DATA,
    output logic             RX_VALID
);

    localparam int TA_W = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;
    localparam logic [TA_W-1:0] TA_LOAD = TA_W'(TURNAROUND - 1);

    typedef enum logic [1:0] {
        ST_RX    = 2'd0,
        ST_TA_TX = 2'd1,
        ST_TX    = 2'd2,
        ST_TA_RX = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [TA_W-1:0]  r_ta_cnt;
    logic [TA_W-1:0]  w_ta_cnt_next;
    logic [LEN_W-1:0] r_beat_cnt;
    logic [LEN_W-1:0] w_beat_cnt_next;
    logic [1:0]       r_burst_cnt;
    logic [1:0]       w_burst_cnt_next;
    logic             r_ptr;
    logic             w_ptr_next;
    logic             r_sel;
    logic             w_sel_next;
    logic [1:0]       r_gnt;
    logic [1:0]       w_gnt_next;
    logic             r_rst_exit;
    logic             w_rst_exit_next;
    logic             w_pad_en_next;

    logic [WIDTH-1:0] r_pad_o;
    logic             r_pad_t;
    logic             r_pad_en;
    logic [WIDTH-1:0] r_rx_data;
    logic             r_rx_valid;

    logic [1:0]       w_req;
    logic             w_any_req;
    logic             w_win;
    logic [1:0]       w_win_oh;
    logic [LEN_W-1:0] w_len [2];
    logic [WIDTH-1:0] w_data [2];
    logic [LEN_W-1:0] w_win_len;
    logic             w_ta_done;

    assign w_req     = {REQ1, REQ0};
    assign w_len[0]  = LEN0;
    assign w_len[1]  = LEN1;
    assign w_data[0] = DATA0;
    assign w_data[1] = DATA1;
    assign w_any_req = |w_req;

    // With both requesting, the pointer names the requester not granted most recently.
    assign w_win     = (w_req == 2'b11) ? r_ptr : w_req[1];
    assign w_win_len = w_len[w_win];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_win_oh
            assign w_win_oh[gi] = (w_win == 1'(gi));
        end
    endgenerate

    // Leaving reset the outputs are already idle, so one dead cycle is already spent.
    assign w_ta_done = (r_ta_cnt == '0) || (r_rst_exit && (r_ta_cnt == TA_W'(1)));

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= ST_TA_RX;
            r_ta_cnt    <= TA_LOAD;
            r_beat_cnt  <= '0;
            r_burst_cnt <= '0;
            r_ptr       <= 1'b0;
            r_sel       <= 1'b0;
            r_gnt       <= '0;
            r_rst_exit  <= 1'b1;
        end else begin
            r_state     <= w_state_next;
            r_ta_cnt    <= w_ta_cnt_next;
            r_beat_cnt  <= w_beat_cnt_next;
            r_burst_cnt <= w_burst_cnt_next;
            r_ptr       <= w_ptr_next;
            r_sel       <= w_sel_next;
            r_gnt       <= w_gnt_next;
            r_rst_exit  <= w_rst_exit_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_ta_cnt_next    = r_ta_cnt;
        w_beat_cnt_next  = r_beat_cnt;
        w_burst_cnt_next = r_burst_cnt;
        w_ptr_next       = r_ptr;
        w_sel_next       = r_sel;
        w_gnt_next       = r_gnt;
        w_rst_exit_next  = r_rst_exit;
        w_pad_en_next    = 1'b0;
        case (r_state)
            ST_RX: begin
                w_pad_en_next    = 1'b1;
                w_burst_cnt_next = '0;
                w_rst_exit_next  = 1'b0;
                if (w_any_req) begin
                    w_state_next    = ST_TA_TX;
                    w_sel_next      = w_win;
                    w_ptr_next      = ~w_win;
                    w_beat_cnt_next = w_win_len - LEN_W'(1);
                    w_ta_cnt_next   = TA_LOAD;
                end
            end
            ST_TA_TX: begin
                if (r_ta_cnt == '0) begin
                    w_state_next     = ST_TX;
                    w_gnt_next       = r_sel ? 2'b10 : 2'b01;
                    w_burst_cnt_next = 2'd1;
                end else begin
                    w_ta_cnt_next = r_ta_cnt - TA_W'(1);
                end
            end
            ST_TX: begin
                if (r_beat_cnt == '0) begin
                    // Chain at most one extra burst so the receiver always gets a window.
                    if (w_any_req && (r_burst_cnt < 2'd2)) begin
                        w_sel_next       = w_win;
                        w_ptr_next       = ~w_win;
                        w_beat_cnt_next  = w_win_len - LEN_W'(1);
                        w_gnt_next       = w_win_oh;
                        w_burst_cnt_next = r_burst_cnt + 2'd1;
                    end else begin
                        w_state_next  = ST_TA_RX;
                        w_gnt_next    = '0;
                        w_ta_cnt_next = TA_LOAD;
                    end
                end else begin
                    w_beat_cnt_next = r_beat_cnt - LEN_W'(1);
                end
            end
            ST_TA_RX: begin
                w_pad_en_next = r_rst_exit && (r_ta_cnt == '0);
                if (w_ta_done) begin
                    w_state_next = ST_RX;
                end else begin
                    w_ta_cnt_next = r_ta_cnt - TA_W'(1);
                end
            end
            default: begin
                w_state_next = ST_TA_RX;
                w_gnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pad_o    <= '0;
            r_pad_t    <= 1'b0;
            r_pad_en   <= 1'b0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
        end else begin
            r_pad_t    <= |r_gnt;
            r_pad_en   <= w_pad_en_next;
            r_rx_valid <= r_pad_en;
            if (|r_gnt) begin
                r_pad_o <= w_data[r_sel];
            end
            if (r_pad_en) begin
                r_rx_data <= PAD_I;
            end
        end
    end

    assign GNT0     = r_gnt[0];
    assign GNT1     = r_gnt[1];
    assign ACK0     = r_gnt[0];
    assign ACK1     = r_gnt[1];
    assign PAD_O    = r_pad_o;
    assign PAD_T    = r_pad_t;
    assign PAD_EN   = r_pad_en;
    assign RX_DATA  = r_rx_data;
    assign RX_VALID = r_rx_valid;

endmodule

// File: tb/tb_io_bidir_arbiter.sv
// Directed bench for io_bidir_arbiter: per-edge expected bus state for each scenario.
module tb_io_bidir_arbiter;

    localparam int WIDTH = 8;
    localparam int LEN_W = 4;
    localparam int TURNAROUND = 2;

    // Expected bus state codes: {GNT0, GNT1, PAD_T, PAD_EN}; ACKi is expected equal to GNTi.
    localparam logic [3:0] S_DEAD = 4'b0000;
    localparam logic [3:0] S_RX   = 4'b0001;
    localparam logic [3:0] S_T    = 4'b0010;
    localparam logic [3:0] S_G0   = 4'b1000;
    localparam logic [3:0] S_G0T  = 4'b1010;
    localparam logic [3:0] S_G1T  = 4'b0110;

    logic             CLK;
    logic             RST;
    logic             REQ0, REQ1;
    logic [LEN_W-1:0] LEN0, LEN1;
    logic [WIDTH-1:0] DATA0, DATA1;
    logic             GNT0, GNT1, ACK0, ACK1;
    logic [WIDTH-1:0] PAD_O;
    logic             PAD_T, PAD_EN;
    logic [WIDTH-1:0] PAD_I;
    logic [WIDTH-1:0] RX_DATA;
    logic             RX_VALID;

    int               n_checks;
    int               n_errors;
    int               n_overlap;
    logic [WIDTH-1:0] base0, base1;
    int               idx0, idx1;

    io_bidir_arbiter #(
        .WIDTH(WIDTH),
        .LEN_W(LEN_W),
        .TURNAROUND(TURNAROUND)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .REQ0(REQ0),
        .REQ1(REQ1),
        .LEN0(LEN0),
        .LEN1(LEN1),
        .DATA0(DATA0),
        .DATA1(DATA1),
        .GNT0(GNT0),
        .GNT1(GNT1),
        .ACK0(ACK0),
        .ACK1(ACK1),
        .PAD_O(PAD_O),
        .PAD_T(PAD_T),
        .PAD_EN(PAD_EN),
        .PAD_I(PAD_I),
        .RX_DATA(RX_DATA),
        .RX_VALID(RX_VALID)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; the fabric model presents the next beat after each consumed one.
    task automatic tick();
        logic a0, a1;
        a0 = ACK0;
        a1 = ACK1;
        @(posedge CLK);
        #1;
        if (a0 === 1'b1) idx0++;
        if (a1 === 1'b1) idx1++;
        DATA0 = 8'(base0 + 8'(idx0));
        DATA1 = 8'(base1 + 8'(idx1));
        if (PAD_T === 1'b1 && PAD_EN === 1'b1) n_overlap++;
    endtask

    task automatic step(input string tag, input int n, input logic [3:0] exp_s);
        tick();
        check_val($sformatf("%s_%0d", tag, n),
                  {26'd0, GNT0, ACK0, GNT1, ACK1, PAD_T, PAD_EN},
                  {26'd0, exp_s[3], exp_s[3], exp_s[2], exp_s[2], exp_s[1], exp_s[0]});
    endtask

    task automatic apply_reset(input string tag);
        RST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step({tag, "_rst"}, i, S_DEAD);
            check_val($sformatf("%s_rst_pado_%0d", tag, i), {24'd0, PAD_O}, 32'h0);
            check_val($sformatf("%s_rst_rxv_%0d", tag, i), {31'd0, RX_VALID}, 32'h0);
            check_val($sformatf("%s_rst_rxd_%0d", tag, i), {24'd0, RX_DATA}, 32'h0);
        end
        RST = 1'b0;
        step({tag, "_post"}, 0, S_DEAD);
        step({tag, "_post"}, 1, S_RX);
        check_val({tag, "_post_rxv1"}, {31'd0, RX_VALID}, 32'h0);
        step({tag, "_post"}, 2, S_RX);
        check_val({tag, "_post_rxv2"}, {31'd0, RX_VALID}, 32'h1);
        check_val({tag, "_post_rxd2"}, {24'd0, RX_DATA}, 32'h5C);
        step({tag, "_post"}, 3, S_RX);
        $display("txn %s: reset and return to receive", tag);
    endtask

    initial begin
        int n_ack;
        int n_beat;
        n_checks = 0;
        n_errors = 0;
        n_overlap = 0;
        RST = 1'b1;
        REQ0 = 1'b0;
        REQ1 = 1'b0;
        LEN0 = '0;
        LEN1 = '0;
        base0 = '0;
        base1 = '0;
        idx0 = 0;
        idx1 = 0;
        DATA0 = '0;
        DATA1 = '0;
        PAD_I = 8'h5C;

        apply_reset("por");

        // Single 3-beat burst; LEN0 changes after the decision and must be ignored.
        REQ0 = 1'b1; LEN0 = 4'd3; base0 = 8'hA1; idx0 = 0; DATA0 = 8'hA1;
        step("sb", 0, S_RX);
        check_val("sb_rxv0", {31'd0, RX_VALID}, 32'h1);
        REQ0 = 1'b0; LEN0 = 4'd7;
        step("sb", 1, S_DEAD);
        PAD_I = 8'h3E;
        step("sb", 2, S_G0);
        step("sb", 3, S_G0T);
        check_val("sb_pado3", {24'd0, PAD_O}, 32'hA1);
        step("sb", 4, S_G0T);
        check_val("sb_pado4", {24'd0, PAD_O}, 32'hA2);
        step("sb", 5, S_T);
        check_val("sb_pado5", {24'd0, PAD_O}, 32'hA3);
        step("sb", 6, S_DEAD);
        check_val("sb_pado6", {24'd0, PAD_O}, 32'hA3);
        step("sb", 7, S_DEAD);
        check_val("sb_rxd7", {24'd0, RX_DATA}, 32'h5C);
        check_val("sb_rxv7", {31'd0, RX_VALID}, 32'h0);
        step("sb", 8, S_RX);
        check_val("sb_rxv8", {31'd0, RX_VALID}, 32'h0);
        step("sb", 9, S_RX);
        check_val("sb_rxv9", {31'd0, RX_VALID}, 32'h1);
        check_val("sb_rxd9", {24'd0, RX_DATA}, 32'h3E);
        $display("txn single burst: requester 0, 3 beats");

        // Reset lands on the 2nd ACK of a 5-beat burst while PAD_T=1.
        PAD_I = 8'h5C;
        REQ0 = 1'b1; LEN0 = 4'd5; base0 = 8'h30; idx0 = 0; DATA0 = 8'h30;
        step("mr", 0, S_RX);
        REQ0 = 1'b0;
        step("mr", 1, S_DEAD);
        step("mr", 2, S_G0);
        step("mr", 3, S_G0T);
        check_val("mr_pado3", {24'd0, PAD_O}, 32'h30);
        apply_reset("mr");

        // Simultaneous requests after reset: 0 first, 1 chained with no PAD_T gap.
        REQ0 = 1'b1; REQ1 = 1'b1; LEN0 = 4'd2; LEN1 = 4'd2;
        base0 = 8'h10; base1 = 8'h20; idx0 = 0; idx1 = 0; DATA0 = 8'h10; DATA1 = 8'h20;
        step("sim", 0, S_RX);
        REQ0 = 1'b0;
        step("sim", 1, S_DEAD);
        step("sim", 2, S_G0);
        step("sim", 3, S_G0T);
        check_val("sim_pado3", {24'd0, PAD_O}, 32'h10);
        step("sim", 4, S_G1T);
        check_val("sim_pado4", {24'd0, PAD_O}, 32'h11);
        REQ1 = 1'b0;
        step("sim", 5, S_G1T);
        check_val("sim_pado5", {24'd0, PAD_O}, 32'h20);
        step("sim", 6, S_T);
        check_val("sim_pado6", {24'd0, PAD_O}, 32'h21);
        step("sim", 7, S_DEAD);
        step("sim", 8, S_DEAD);
        step("sim", 9, S_RX);
        $display("txn simultaneous: grant 0 then 1 chained");

        // Both held high: 0,1,RX,0,1,RX with a receive window between pairs.
        REQ0 = 1'b1; REQ1 = 1'b1; LEN0 = 4'd1; LEN1 = 4'd1;
        step("stv", 0, S_RX);
        step("stv", 1, S_DEAD);
        step("stv", 2, S_G0);
        step("stv", 3, S_G1T);
        step("stv", 4, S_T);
        step("stv", 5, S_DEAD);
        step("stv", 6, S_DEAD);
        step("stv", 7, S_RX);
        step("stv", 8, S_DEAD);
        step("stv", 9, S_G0);
        step("stv", 10, S_G1T);
        step("stv", 11, S_T);
        step("stv", 12, S_DEAD);
        step("stv", 13, S_DEAD);
        REQ0 = 1'b0; REQ1 = 1'b0;
        step("stv", 14, S_RX);
        step("stv", 15, S_RX);
        $display("txn starvation guard: two chained pairs with receive window");

        // LEN=0 encodes 16 beats.
        REQ1 = 1'b1; LEN1 = 4'd0; base1 = 8'hC0; idx1 = 0; DATA1 = 8'hC0;
        tick();
        REQ1 = 1'b0;
        n_ack = 0;
        n_beat = 0;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (ACK1 === 1'b1) n_ack++;
            if (PAD_T === 1'b1) begin
                check_val($sformatf("wrap_beat%0d", n_beat), {24'd0, PAD_O},
                          {24'd0, 8'(8'hC0 + 8'(n_beat))});
                n_beat++;
            end
        end
        check_val("wrap_ack_count", n_ack, 32'd16);
        check_val("wrap_beat_count", n_beat, 32'd16);
        check_val("wrap_pad_en_end", {31'd0, PAD_EN}, 32'h1);
        $display("txn len wrap: requester 1, %0d acks, %0d beats", n_ack, n_beat);

        check_val("t_en_overlap", n_overlap, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
